// File: rtl/config_pkg.sv
// Global backend configuration: datapath/PC widths and default ALU pipeline depth.
package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
      int unsigned PLEN;
   } cfg_t;

   localparam cfg_t EmptyCfg = '{XLEN: 32, PLEN: 32};

   localparam int unsigned AluLatency = 1;

endpackage

// File: rtl/decode_pkg.sv
// Decoded micro-op and execute result bundle shared by issue, execute and writeback.
package decode_pkg;

   localparam int unsigned UopXlen = config_pkg::EmptyCfg.XLEN;
   localparam int unsigned UopPlen = config_pkg::EmptyCfg.PLEN;
   localparam int unsigned ResTagW = 6;

   typedef enum logic [3:0] {
      AluAdd   = 4'd0,
      AluSub   = 4'd1,
      AluLui   = 4'd2,
      AluAuipc = 4'd3,
      AluAnd   = 4'd4,
      AluOr    = 4'd5,
      AluXor   = 4'd6,
      AluSll   = 4'd7,
      AluSrl   = 4'd8,
      AluSra   = 4'd9,
      AluSlt   = 4'd10,
      AluSltu  = 4'd11
   } alu_op_e;

   typedef enum logic [2:0] {
      BrEq   = 3'd0,
      BrNe   = 3'd1,
      BrLt   = 3'd2,
      BrGe   = 3'd3,
      BrLtu  = 3'd4,
      BrGeu  = 3'd5,
      BrJal  = 3'd6,
      BrJalr = 3'd7
   } br_op_e;

   typedef struct packed {
      alu_op_e            alu_op;
      br_op_e             br_op;
      logic               is_branch;
      logic               is_jump;
      logic               has_rs2;
      logic [UopPlen-1:0] pc;
      logic [UopXlen-1:0] imm;   // already sign-extended by decode
   } uop_t;

   typedef struct packed {
      logic [ResTagW-1:0] tag;
      logic [UopXlen-1:0] result;
      logic               mispred;
      logic [UopPlen-1:0] redirect;
   } alu_res_t;

endpackage

// File: rtl/execute_alu_core.sv
// Stage-0 combinational compute: ALU result, branch resolution and mispredict detection.
module execute_alu_core
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned PC_W = 32
) (
   input  uop_t             uop_i,
   input  logic [XLEN-1:0]  rs1_data_i,
   input  logic [XLEN-1:0]  rs2_data_i,
   input  logic             is_rvc_i,
   input  logic             pred_taken_i,
   input  logic [PC_W-1:0]  pred_target_i,
   output alu_res_t         res_o
);

   localparam int unsigned ShW = $clog2(XLEN);

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] isz;
   logic [PC_W-1:0] fallthrough;
   logic [PC_W-1:0] target;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] result;
   logic [ShW-1:0]  shamt;
   logic            is_ctrl;
   logic            cmp;
   logic            taken;
   logic            mispred;

   assign pc    = uop_i.pc[PC_W-1:0];
   assign imm   = uop_i.imm[XLEN-1:0];
   assign op_a  = (uop_i.alu_op == AluAuipc) ? XLEN'(pc) : rs1_data_i;
   assign op_b  = uop_i.has_rs2 ? rs2_data_i : imm;
   assign shamt = op_b[ShW-1:0];

   always_comb begin
      alu_res = '0;
      case (uop_i.alu_op)
         AluAdd, AluAuipc: alu_res = op_a + op_b;
         AluSub:           alu_res = op_a - op_b;
         AluLui:           alu_res = op_b;
         AluAnd:           alu_res = op_a & op_b;
         AluOr:            alu_res = op_a | op_b;
         AluXor:           alu_res = op_a ^ op_b;
         AluSll:           alu_res = op_a << shamt;
         AluSrl:           alu_res = op_a >> shamt;
         AluSra:           alu_res = XLEN'($signed(op_a) >>> shamt);
         AluSlt:           alu_res = XLEN'($signed(op_a) < $signed(op_b));
         AluSltu:          alu_res = XLEN'(op_a < op_b);
         default:          alu_res = '0;
      endcase
   end

   // Branch compares always use the register operands, never the immediate.
   always_comb begin
      cmp = 1'b0;
      case (uop_i.br_op)
         BrEq:          cmp = (rs1_data_i == rs2_data_i);
         BrNe:          cmp = (rs1_data_i != rs2_data_i);
         BrLt:          cmp = ($signed(rs1_data_i) < $signed(rs2_data_i));
         BrGe:          cmp = ($signed(rs1_data_i) >= $signed(rs2_data_i));
         BrLtu:         cmp = (rs1_data_i < rs2_data_i);
         BrGeu:         cmp = (rs1_data_i >= rs2_data_i);
         BrJal, BrJalr: cmp = 1'b1;
         default:       cmp = 1'b0;
      endcase
   end

   assign isz         = is_rvc_i ? PC_W'(2) : PC_W'(4);
   assign fallthrough = pc + isz;
   assign target      = (uop_i.br_op == BrJalr) ?
                        PC_W'((rs1_data_i + imm) & ~XLEN'(1)) :
                        pc + PC_W'($signed(imm));

   assign is_ctrl = uop_i.is_branch | uop_i.is_jump;
   assign taken   = uop_i.is_jump | (uop_i.is_branch & cmp);
   assign mispred = is_ctrl & ((taken != pred_taken_i) |
                               (taken & pred_taken_i & (target != pred_target_i)));

   always_comb begin
      if (uop_i.is_jump) begin
         result = XLEN'(fallthrough);
      end else if (uop_i.is_branch) begin
         result = '0;
      end else begin
         result = alu_res;
      end
   end

   always_comb begin
      res_o                     = '0;
      res_o.result[XLEN-1:0]    = result;
      res_o.mispred             = mispred;
      if (mispred) begin
         res_o.redirect[PC_W-1:0] = taken ? target : fallthrough;
      end
   end

endmodule

// File: rtl/execute_alu_pipe.sv
// Pipelined execute ALU: stage-0 compute followed by LATENCY valid/ready register stages.
module execute_alu_pipe
   import decode_pkg::*;
#(
   parameter config_pkg::cfg_t Cfg     = config_pkg::EmptyCfg,
   parameter int unsigned      TAG_W   = 6,
   parameter int unsigned      XLEN    = Cfg.XLEN,
   parameter int unsigned      PC_W    = Cfg.PLEN,
   parameter int unsigned      LATENCY = config_pkg::AluLatency
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  uop_t              uop_i,
   input  logic [XLEN-1:0]   rs1_data_i,
   input  logic [XLEN-1:0]   rs2_data_i,
   input  logic [TAG_W-1:0]  rob_tag_i,
   input  logic              is_rvc_i,
   input  logic              pred_taken_i,
   input  logic [PC_W-1:0]   pred_target_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [TAG_W-1:0]  out_rob_tag_o,
   output logic [XLEN-1:0]   out_result_o,
   output logic              out_is_mispred_o,
   output logic [PC_W-1:0]   out_redirect_pc_o
);

   if (LATENCY < 1 || LATENCY > 4) begin : gen_bad_latency
      $error("execute_alu_pipe: LATENCY must be in 1..4");
   end
   if (XLEN > UopXlen || PC_W > UopPlen || TAG_W > ResTagW) begin : gen_bad_width
      $error("execute_alu_pipe: widths exceed decode_pkg bundle widths");
   end

   alu_res_t core_res;
   alu_res_t s0_res;

   execute_alu_core #(
      .XLEN (XLEN),
      .PC_W (PC_W)
   ) u_core (
      .uop_i         (uop_i),
      .rs1_data_i    (rs1_data_i),
      .rs2_data_i    (rs2_data_i),
      .is_rvc_i      (is_rvc_i),
      .pred_taken_i  (pred_taken_i),
      .pred_target_i (pred_target_i),
      .res_o         (core_res)
   );

   always_comb begin
      s0_res     = core_res;
      s0_res.tag = ResTagW'(rob_tag_i);
   end

   logic [LATENCY-1:0]            valid_d, valid_q;
   logic [LATENCY-1:0]            ld;
   logic [LATENCY-1:0][TAG_W-1:0] tag_d, tag_q;
   logic [LATENCY-1:0][XLEN-1:0]  result_d, result_q;
   logic [LATENCY-1:0]            mispred_d, mispred_q;
   logic [LATENCY-1:0][PC_W-1:0]  redirect_d, redirect_q;

   // Stage k can load iff some stage at or after k is empty, or the consumer drains.
   always_comb begin
      logic full_tail;
      full_tail = 1'b1;
      ld        = '0;
      for (int k = LATENCY - 1; k >= 0; k--) begin
         full_tail = full_tail & valid_q[k];
         ld[k]     = out_ready_i | ~full_tail;
      end
   end

   assign in_ready_o = ld[0];

   always_comb begin
      valid_d    = valid_q;
      tag_d      = tag_q;
      result_d   = result_q;
      mispred_d  = mispred_q;
      redirect_d = redirect_q;

      if (ld[0]) begin
         valid_d[0] = in_valid_i;
         if (in_valid_i) begin
            tag_d[0]      = s0_res.tag[TAG_W-1:0];
            result_d[0]   = s0_res.result[XLEN-1:0];
            mispred_d[0]  = s0_res.mispred;
            redirect_d[0] = s0_res.redirect[PC_W-1:0];
         end
      end

      for (int k = 1; k < LATENCY; k++) begin
         if (ld[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               tag_d[k]      = tag_q[k-1];
               result_d[k]   = result_q[k-1];
               mispred_d[k]  = mispred_q[k-1];
               redirect_d[k] = redirect_q[k-1];
            end
         end
      end

      // Data may load on a flush cycle; only the valids matter.
      if (flush_i) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q    <= '0;
         tag_q      <= '0;
         result_q   <= '0;
         mispred_q  <= '0;
         redirect_q <= '0;
      end else begin
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         result_q   <= result_d;
         mispred_q  <= mispred_d;
         redirect_q <= redirect_d;
      end
   end

   assign out_valid_o       = valid_q[LATENCY-1];
   assign out_rob_tag_o     = tag_q[LATENCY-1];
   assign out_result_o      = result_q[LATENCY-1];
   assign out_is_mispred_o  = mispred_q[LATENCY-1];
   assign out_redirect_pc_o = redirect_q[LATENCY-1];

endmodule

// File: tb/tb_execute_alu_pipe.sv
// Scoreboard bench for execute_alu_pipe with LATENCY=2 and 32-bit datapath.
module tb_execute_alu_pipe;
   import decode_pkg::*;

   typedef struct {
      uop_t        uop;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [5:0]  tag;
      logic        rvc;
      logic        pt;
      logic [31:0] ptg;
      logic [31:0] eres;
      logic        emis;
      logic [31:0] eredir;
   } vec_t;

   typedef struct {
      logic [5:0]  tag;
      logic [31:0] res;
      logic        mis;
      logic [31:0] redir;
   } exp_t;

   logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   uop_t        uop;
   logic [31:0] rs1, rs2, ptg, out_res, out_redir;
   logic [5:0]  tag, out_tag;
   logic        rvc, pt, out_mis;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   vec_t vecs[$];

   execute_alu_pipe #(
      .TAG_W   (6),
      .LATENCY (2)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .flush_i           (flush),
      .in_valid_i        (in_valid),
      .in_ready_o        (in_ready),
      .uop_i             (uop),
      .rs1_data_i        (rs1),
      .rs2_data_i        (rs2),
      .rob_tag_i         (tag),
      .is_rvc_i          (rvc),
      .pred_taken_i      (pt),
      .pred_target_i     (ptg),
      .out_valid_o       (out_valid),
      .out_ready_i       (out_ready),
      .out_rob_tag_o     (out_tag),
      .out_result_o      (out_res),
      .out_is_mispred_o  (out_mis),
      .out_redirect_pc_o (out_redir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // kind: 0 = ALU, 1 = branch, 2 = jump
   function automatic vec_t mk(input logic [5:0] t, input alu_op_e aop, input br_op_e bop,
                               input logic [1:0] kind, input logic hr2,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic c, input logic p, input logic [31:0] pg,
                               input logic [31:0] er, input logic em, input logic [31:0] ed);
      vec_t v;
      v.uop.alu_op    = aop;
      v.uop.br_op     = bop;
      v.uop.is_branch = (kind == 2'd1);
      v.uop.is_jump   = (kind == 2'd2);
      v.uop.has_rs2   = hr2;
      v.uop.pc        = pc;
      v.uop.imm       = imm;
      v.rs1 = a;  v.rs2 = b;  v.tag = t;  v.rvc = c;  v.pt = p;  v.ptg = pg;
      v.eres = er;  v.emis = em;  v.eredir = ed;
      return v;
   endfunction

   // Must be called after a posedge and before the following negedge.
   task automatic send(input vec_t v, input logic do_flush);
      logic acc;
      acc      = 1'b0;
      uop      = v.uop;
      rs1      = v.rs1;
      rs2      = v.rs2;
      tag      = v.tag;
      rvc      = v.rvc;
      pt       = v.pt;
      ptg      = v.ptg;
      in_valid = 1'b1;
      flush    = do_flush;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            exp_q.push_back('{tag: v.tag, res: v.eres, mis: v.emis, redir: v.eredir});
         end
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout tag=%0d actual in_ready=%b required=1", v.tag, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      if (do_flush) exp_q.delete();
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual tag=%0d required=no output", out_tag);
         end else begin
            e = exp_q.pop_front();
            chk("out_tag", 32'(out_tag), 32'(e.tag));
            chk("out_result", out_res, e.res);
            chk("out_mispred", 32'(out_mis), 32'(e.mis));
            chk("out_redirect", out_redir, e.redir);
         end
      end
   end

   initial begin
      rst_n = 1'b0;  flush = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
      uop = '0;  rs1 = '0;  rs2 = '0;  tag = '0;  rvc = 1'b0;  pt = 1'b0;  ptg = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_out_result", out_res, 32'd0);
      chk("rst_out_mispred", 32'(out_mis), 32'd0);
      chk("rst_out_redirect", out_redir, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;

      // Latency: ADD accepted at edge n is visible after edge n+1.
      align();
      send(mk(6'd3, AluAdd, BrEq, 2'd0, 1'b1, 32'h0, 32'h0, 32'd5, 32'd7,
              1'b0, 1'b0, 32'h0, 32'd12, 1'b0, 32'h0), 1'b0);
      @(negedge clk);
      chk("lat_early_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid", 32'(out_valid), 32'd1);
      drain();

      vecs.push_back(mk(1, AluSub, BrEq, 0, 1, 0, 0, 3, 5, 0, 0, 0, 32'hFFFF_FFFE, 0, 0));
      vecs.push_back(mk(2, AluLui, BrEq, 0, 0, 0, 32'h1234_5000, 7, 9, 0, 0, 0,
                        32'h1234_5000, 0, 0));
      vecs.push_back(mk(4, AluAuipc, BrEq, 0, 0, 32'h1000, 32'h2000, 32'hDEAD, 0, 0, 0, 0,
                        32'h3000, 0, 0));
      vecs.push_back(mk(5, AluAnd, BrEq, 0, 1, 0, 0, 32'hF0F0, 32'hFF00, 0, 0, 0,
                        32'hF000, 0, 0));
      vecs.push_back(mk(6, AluOr, BrEq, 0, 1, 0, 0, 32'hF0F0, 32'hFF00, 0, 0, 0,
                        32'hFFF0, 0, 0));
      vecs.push_back(mk(7, AluXor, BrEq, 0, 1, 0, 0, 32'hF0F0, 32'hFF00, 0, 0, 0,
                        32'h0FF0, 0, 0));
      vecs.push_back(mk(8, AluSll, BrEq, 0, 1, 0, 0, 1, 32'h24, 0, 0, 0, 32'h10, 0, 0));
      vecs.push_back(mk(9, AluSrl, BrEq, 0, 1, 0, 0, 32'h8000_0000, 4, 0, 0, 0,
                        32'h0800_0000, 0, 0));
      vecs.push_back(mk(10, AluSra, BrEq, 0, 1, 0, 0, 32'h8000_0000, 4, 0, 0, 0,
                        32'hF800_0000, 0, 0));
      vecs.push_back(mk(11, AluSlt, BrEq, 0, 1, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(12, AluSltu, BrEq, 0, 1, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(13, AluAdd, BrEq, 0, 0, 0, 32'hFFFF_FFFF, 32'h100, 9, 0, 0, 0,
                        32'hFF, 0, 0));
      vecs.push_back(mk(14, alu_op_e'(4'hF), BrEq, 0, 1, 0, 0, 3, 4, 0, 0, 0, 0, 0, 0));
      // Branches: pc 0x100, imm 0x40, target 0x140
      vecs.push_back(mk(15, AluAdd, BrEq, 1, 1, 32'h100, 32'h40, 1, 1, 0, 1, 32'h140,
                        0, 0, 0));
      vecs.push_back(mk(16, AluAdd, BrNe, 1, 1, 32'h100, 32'h40, 1, 2, 0, 1, 32'h180,
                        0, 1, 32'h140));
      vecs.push_back(mk(17, AluAdd, BrNe, 1, 1, 32'h100, 32'h40, 1, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(18, AluAdd, BrLt, 1, 1, 32'h100, 32'h40, 5, 3, 0, 1, 32'h140,
                        0, 1, 32'h104));
      vecs.push_back(mk(19, AluAdd, BrGeu, 1, 1, 32'h100, 32'h40, 1, 32'hFFFF_FFFF, 0, 0, 0,
                        0, 0, 0));
      vecs.push_back(mk(20, AluAdd, BrGe, 1, 1, 32'h100, 32'h40, 1, 32'hFFFF_FFFF, 0, 0, 0,
                        0, 1, 32'h140));
      // Jumps
      vecs.push_back(mk(21, AluAdd, BrJal, 2, 0, 32'h200, 32'h20, 0, 0, 1, 0, 0,
                        32'h202, 1, 32'h220));
      vecs.push_back(mk(22, AluAdd, BrJalr, 2, 0, 32'h300, 0, 32'h1001, 0, 0, 0, 0,
                        32'h304, 1, 32'h1000));
      vecs.push_back(mk(23, AluAdd, BrJal, 2, 0, 32'h200, 32'hFFFF_FFF0, 0, 0, 0, 1, 32'h1F0,
                        32'h204, 0, 0));
      vecs.push_back(mk(24, AluAdd, BrJal, 2, 0, 32'h200, 32'hFFFF_FFF0, 0, 0, 0, 1, 32'h1F4,
                        32'h204, 1, 32'h1F0));

      align();
      foreach (vecs[i]) send(vecs[i], 1'b0);
      drain();

      // Backpressure: 6 ops with the consumer stalled until the pipe fills.
      out_ready = 1'b0;
      align();
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               send(mk(6'(30 + i), AluAdd, BrEq, 0, 1, 0, 0, 32'(i), 32'h100, 0, 0, 0,
                       32'h100 + 32'(i), 0, 0), 1'b0);
            end
         end
         begin
            logic [31:0] s_res, s_red;
            logic [5:0]  s_tag;
            logic        s_mis;
            repeat (3) @(negedge clk);
            chk("bp_in_ready_full", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_head_tag", 32'(out_tag), 32'd30);
            s_res = out_res;  s_red = out_redir;  s_tag = out_tag;  s_mis = out_mis;
            @(negedge clk);
            chk("bp_stable_tag", 32'(out_tag), 32'(s_tag));
            chk("bp_stable_result", out_res, s_res);
            chk("bp_stable_mispred", 32'(out_mis), 32'(s_mis));
            chk("bp_stable_redirect", out_redir, s_red);
            chk("bp_in_ready_held", 32'(in_ready), 32'd0);
            @(posedge clk);
            #2;
            out_ready = 1'b1;
         end
      join
      drain();

      // Flush while ops are in flight and a fourth is being accepted.
      align();
      for (int i = 0; i < 4; i++) begin
         send(mk(6'(40 + i), AluAdd, BrEq, 0, 1, 0, 0, 32'(i), 1, 0, 0, 0,
                 32'(i) + 32'd1, 0, 0), (i == 3));
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("flush_no_valid", 32'(out_valid), 32'd0);
      end
      align();
      send(mk(6'd50, AluXor, BrEq, 0, 1, 0, 0, 32'hAAAA, 32'h5555, 0, 0, 0,
              32'hFFFF, 0, 0), 1'b0);
      drain();

      // Asynchronous reset with an op on the output.
      out_ready = 1'b0;
      align();
      send(mk(6'd60, AluAdd, BrEq, 0, 1, 0, 0, 2, 3, 0, 0, 0, 5, 0, 0), 1'b0);
      @(posedge clk);
      #1;
      chk("pre_reset_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_result", out_res, 32'd0);
      chk("async_rst_tag", 32'(out_tag), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
